// File: rtl/object_stats_reader_pkg.sv
// Shared definitions for the object statistics readout engine:
// default widths, record field count and the scan state encoding.
package object_stats_reader_pkg;

  localparam int LBL_WIDTH  = 8;
  localparam int LOC_SIZE   = 16;
  // Record order in out_data, LSB first: area,x,y,m02,m11,m20,m30,m21,m12,m03
  localparam int OBJ_FIELDS = 10;

  typedef enum logic [1:0] {
    OSR_IDLE = 2'd0,
    OSR_WAIT = 2'd1,
    OSR_EMIT = 2'd2,
    OSR_DONE = 2'd3
  } osr_state_e;

endpackage

// File: rtl/object_stats_reader.sv
// Post-frame readout: walks labels 1..num_labels-1 through the labeler's stats
// read port and streams out every object whose area reaches min_area.
module object_stats_reader
  import object_stats_reader_pkg::*;
#(
  parameter int LBL_W        = LBL_WIDTH,
  parameter int LOC_W        = LOC_SIZE,
  parameter int READ_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [LBL_W-1:0]            num_labels,
  input  logic [LOC_W-1:0]            min_area,
  output logic [LBL_W-1:0]            obj_id,
  input  logic [LOC_W-1:0]            obj_area,
  input  logic [LOC_W-1:0]            obj_x,
  input  logic [LOC_W-1:0]            obj_y,
  input  logic [LOC_W-1:0]            obj_m02,
  input  logic [LOC_W-1:0]            obj_m11,
  input  logic [LOC_W-1:0]            obj_m20,
  input  logic [LOC_W-1:0]            obj_m30,
  input  logic [LOC_W-1:0]            obj_m21,
  input  logic [LOC_W-1:0]            obj_m12,
  input  logic [LOC_W-1:0]            obj_m03,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LBL_W-1:0]            out_id,
  output logic [OBJ_FIELDS*LOC_W-1:0] out_data,
  output logic                        busy,
  output logic                        done,
  output logic [LBL_W-1:0]            obj_count
);

  localparam int WC_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WC_W-1:0] WC_RELOAD = WC_W'(READ_LATENCY - 1);

  osr_state_e state_q, state_d;

  logic [LBL_W-1:0]            obj_id_q, obj_id_d;
  logic [LBL_W-1:0]            last_q, last_d;
  logic [LOC_W-1:0]            min_area_q, min_area_d;
  logic [WC_W-1:0]             wait_cnt_q, wait_cnt_d;
  logic [LBL_W-1:0]            out_id_q, out_id_d;
  logic [OBJ_FIELDS*LOC_W-1:0] rec_q, rec_d;
  logic [LBL_W-1:0]            obj_count_q, obj_count_d;

  logic start_acc, wait_done, pass, hs, advance, at_last;

  assign start_acc = (state_q == OSR_IDLE) && start;
  assign wait_done = (state_q == OSR_WAIT) && (wait_cnt_q == '0);
  assign pass      = (obj_area >= min_area_q);
  assign hs        = (state_q == OSR_EMIT) && out_ready;
  // A label is finished either when rejected at capture or when accepted downstream.
  assign advance   = (wait_done && !pass) || hs;
  assign at_last   = (obj_id_q == last_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= OSR_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OSR_IDLE: if (start) state_d = (num_labels <= LBL_W'(1)) ? OSR_DONE : OSR_WAIT;
      OSR_WAIT: if (wait_done) state_d = pass ? OSR_EMIT : (at_last ? OSR_DONE : OSR_WAIT);
      OSR_EMIT: if (out_ready) state_d = at_last ? OSR_DONE : OSR_WAIT;
      OSR_DONE: state_d = OSR_IDLE;
      default:  state_d = OSR_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == OSR_EMIT);
    busy      = (state_q != OSR_IDLE);
    done      = (state_q == OSR_DONE);
  end

  always_comb begin
    obj_id_d    = obj_id_q;
    last_d      = last_q;
    min_area_d  = min_area_q;
    wait_cnt_d  = wait_cnt_q;
    out_id_d    = out_id_q;
    rec_d       = rec_q;
    obj_count_d = obj_count_q;
    if (start_acc) begin
      last_d      = num_labels - LBL_W'(1);
      min_area_d  = min_area;
      obj_count_d = '0;
      obj_id_d    = LBL_W'(1);
      wait_cnt_d  = WC_RELOAD;
    end
    if ((state_q == OSR_WAIT) && !wait_done) wait_cnt_d = wait_cnt_q - WC_W'(1);
    if (wait_done) begin
      rec_d    = {obj_m03, obj_m12, obj_m21, obj_m30, obj_m20,
                  obj_m11, obj_m02, obj_y, obj_x, obj_area};
      out_id_d = obj_id_q;
    end
    if (hs) obj_count_d = obj_count_q + LBL_W'(1);
    if (advance && !at_last) begin
      obj_id_d   = obj_id_q + LBL_W'(1);
      wait_cnt_d = WC_RELOAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      obj_id_q    <= '0;
      last_q      <= '0;
      min_area_q  <= '0;
      wait_cnt_q  <= '0;
      out_id_q    <= '0;
      rec_q       <= '0;
      obj_count_q <= '0;
    end else begin
      obj_id_q    <= obj_id_d;
      last_q      <= last_d;
      min_area_q  <= min_area_d;
      wait_cnt_q  <= wait_cnt_d;
      out_id_q    <= out_id_d;
      rec_q       <= rec_d;
      obj_count_q <= obj_count_d;
    end
  end

  assign obj_id    = obj_id_q;
  assign out_id    = out_id_q;
  assign out_data  = rec_q;
  assign obj_count = obj_count_q;

endmodule

// File: doc/object_stats_reader.md
# object_stats_reader

Post-frame readout engine for the connected-components labeler. On an end-of-frame `start` pulse it walks every label allocated during the frame, drives `obj_id` into the labeler's object-statistics read port, and captures the returned moment record. It emits each object whose area meets a programmable threshold on a valid/ready stream, then pulses `done` with the emitted count. It sits between the labeler and the downstream feature or classification logic.

## Interface
Parameters:
- `LBL_W`, default `` `LBL_WIDTH ``: label / object-id width.
- `LOC_W`, default `` `LOC_SIZE ``: width of each moment field.
- `READ_LATENCY`, default 2: cycles from a stable `obj_id` to valid `obj_*` data (merge-table read plus data-table read); must be ≥ 1.

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle end-of-frame request; ignored while `busy`.
- `num_labels`  in  LBL_W  next free label from the labeler; labels 1..num_labels-1 are valid.
- `min_area`  in  LOC_W  emit threshold; sampled at `start`.
- `obj_id`  out  LBL_W  registered read address to the labeler.
- `obj_area`, `obj_x`, `obj_y`, `obj_m02`, `obj_m11`, `obj_m20`, `obj_m30`, `obj_m21`, `obj_m12`, `obj_m03`  in  LOC_W each  statistics returned for `obj_id`.
- `out_valid`  out  1  record available.
- `out_ready`  in  1  downstream accepts.
- `out_id`  out  LBL_W  label of the emitted record.
- `out_data`  out  10*LOC_W  captured fields packed {m03,m12,m21,m30,m20,m11,m02,y,x,area}, area in the LSBs.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `obj_count`  out  LBL_W  records accepted in the last scan; held until the next `start`.

## Operation
- States: IDLE, WAIT, EMIT, DONE.
- IDLE + `start`:
  - latch `last = num_labels-1` and `min_area`;
  - clear `obj_count`;
  - set `obj_id <= 1` and `wait_cnt <= READ_LATENCY-1`;
  - go to WAIT. If `num_labels <= 1`, go directly to DONE.
- WAIT: decrement `wait_cnt`. On the edge where `wait_cnt == 0`:
  - capture all `obj_*` into the record registers and set `out_id <= obj_id`;
  - go to EMIT if `obj_area >= min_area_q`, otherwise ADVANCE.
- EMIT: `out_valid = 1`. `out_data` and `out_id` stay stable until the handshake.
  - On `out_valid & out_ready`: `obj_count++`, then ADVANCE.
  - A stalled handshake may last indefinitely.
- ADVANCE (a transition action, not a state):
  - if `obj_id == last`, go to DONE;
  - otherwise `obj_id++`, reload `wait_cnt`, go to WAIT.
- DONE: `done = 1` for exactly one cycle, then IDLE.
- Comparison is unsigned. `min_area = 0` emits every label, including merged or empty ones.
- `obj_count` cannot overflow: at most `2^LBL_W - 2` records per scan.
- `start` asserted in any state other than IDLE has no effect. `num_labels` changing mid-scan has no effect because `last` is latched.
- Reset asserted mid-scan: return immediately to IDLE and drop any pending record; no `done` pulse.

## Timing
- Reset values:
  - `obj_id = 0`, `out_valid = 0`, `out_id = 0`, `out_data = 0`;
  - `busy = 0`, `done = 0`, `obj_count = 0`;
  - state IDLE.
- `obj_id` changes on edge E; data is captured on edge E+READ_LATENCY. Each id is held for exactly READ_LATENCY cycles before capture.
- Throughput with `out_ready` held high:
  - emitted object: READ_LATENCY+1 cycles;
  - rejected object: READ_LATENCY cycles.
- `start` sampled at edge 0 → `busy` high after edge 0 → `obj_id = 1` after edge 0 → first `out_valid` after edge READ_LATENCY.
- `done` rises on the edge after the final ADVANCE. `obj_count` is final in the same cycle as `done`.
- `out_valid` never deasserts without a handshake, except on reset.

## Structure
- `global.vh` gains:
  - `` `OBJ_FIELDS `` (10), with the field order used by `out_data`;
  - `` `OSR_IDLE ``, `` `OSR_WAIT ``, `` `OSR_EMIT ``, `` `OSR_DONE `` state encodings.
- Single flat module; no sub-module. The wait counter and the record register are local.

## Test plan
- `num_labels = 4`, `min_area = 0`, areas {5,0,9}, ready high → three records with ids 1,2,3 and areas 5,0,9; `done` at cycle 3*(RL+1)+1; `obj_count = 3`.
- Same frame, `min_area = 6` → only id 3 emitted; `obj_count = 1`; ids 1–2 each take RL cycles.
- `num_labels = 1` → `done` the cycle after `start`, `obj_count = 0`, `out_valid` never high.
- Stall `out_ready` low for 20 cycles on id 2 → `out_data`/`out_id` stable throughout, `obj_id` frozen, no further reads until accepted.
- Second `start` while busy → ignored, single `done`. Reset pulse mid-EMIT → all outputs return to reset values; a new `start` rescans from id 1.
- RL = 1 and RL = 3 builds with a behavioural model of a latency-RL lookup → every captured record matches the model entry for its `out_id`.
